// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush sequencer for the five-stage core.
// Merges load-use and memory back-pressure into one stall, and runs a
// fixed-length redirect/squash sequence on execute-stage mispredictions.
// Optional macro PIPELINE_CONTROL_PERF_EN enables the saturating
// mispredict and stall performance counters; otherwise they read 0.
module pipeline_control #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_use_hazard,
  input  logic                  mem_busy,
  input  logic                  ex_branch_valid,
  input  logic                  ex_branch_taken,
  input  logic                  ex_predicted_taken,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic [ADDR_WIDTH-1:0] ex_target,
  output logic                  stall,
  output logic                  flush,
  output logic                  nop,
  output logic [ADDR_WIDTH-1:0] branch_address,
  output logic [15:0]           mispredict_count,
  output logic [15:0]           stall_count
);

  localparam int unsigned CNT_WIDTH  = 3;
  localparam int unsigned PERF_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] NOP_LOAD = CNT_WIDTH'(FLUSH_CYCLES - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    nop_cnt, nop_cnt_nxt;
  logic                    flush_nxt;
  logic                    nop_nxt;
  logic [ADDR_WIDTH-1:0]   branch_address_nxt;
  logic                    accept;
  logic                    mispredict;

  // A branch resolves only in RUN and only once memory lets execute advance
  assign accept     = (state == ST_RUN) && ex_branch_valid && !mem_busy;
  assign mispredict = accept && (ex_branch_taken != ex_predicted_taken);

  // Zero-latency freeze; load-use is a wrong-path request while squashing
  assign stall = reset && (mem_busy || (load_use_hazard && (state == ST_RUN)));

  // State and registered control outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_RUN;
      nop_cnt        <= '0;
      flush          <= 1'b0;
      nop            <= 1'b0;
      branch_address <= '0;
    end else begin
      state          <= state_nxt;
      nop_cnt        <= nop_cnt_nxt;
      flush          <= flush_nxt;
      nop            <= nop_nxt;
      branch_address <= branch_address_nxt;
    end
  end

  // Next-state and next-output logic; the squash sequence ignores mem_busy
  always_comb begin
    state_nxt          = state;
    nop_cnt_nxt        = nop_cnt;
    flush_nxt          = 1'b0;
    nop_nxt            = 1'b0;
    branch_address_nxt = branch_address;
    case (state)
      ST_RUN: begin
        if (mispredict) begin
          state_nxt          = ST_FLUSH;
          flush_nxt          = 1'b1;
          nop_nxt            = 1'b1;
          nop_cnt_nxt        = NOP_LOAD;
          branch_address_nxt = ex_branch_taken ? ex_target
                                               : ADDR_WIDTH'(ex_pc + ADDR_WIDTH'(2));
        end
      end
      ST_FLUSH: begin
        if (nop_cnt != '0) begin
          nop_nxt     = 1'b1;
          nop_cnt_nxt = nop_cnt - CNT_WIDTH'(1);
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

`ifdef PIPELINE_CONTROL_PERF_EN
  // Saturating event counters, one cycle behind the event
  always_ff @(posedge clk) begin
    if (!reset) begin
      mispredict_count <= '0;
      stall_count      <= '0;
    end else begin
      if (mispredict && (mispredict_count != '1))
        mispredict_count <= mispredict_count + PERF_WIDTH'(1);
      if (stall && (stall_count != '1))
        stall_count <= stall_count + PERF_WIDTH'(1);
    end
  end
`else
  assign mispredict_count = '0;
  assign stall_count      = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed plus random stimulus for pipeline_control,
// checked each cycle against a timeline model of the flush window.
module tb_pipeline_control;

  localparam int FC = 2;
`ifdef PIPELINE_CONTROL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        load_use_hazard;
  logic        mem_busy;
  logic        ex_branch_valid;
  logic        ex_branch_taken;
  logic        ex_predicted_taken;
  logic [15:0] ex_pc;
  logic [15:0] ex_target;
  logic        stall;
  logic        flush;
  logic        nop;
  logic [15:0] branch_address;
  logic [15:0] mispredict_count;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Model: cycle index, cycle of last accepted mispredict, expected values
  int          cyc;
  int          acc;
  logic [15:0] m_ba;
  int          m_mis;
  int          m_stall;

  pipeline_control #(.ADDR_WIDTH(16), .FLUSH_CYCLES(FC)) dut (
    .clk                (clk),
    .reset              (reset),
    .load_use_hazard    (load_use_hazard),
    .mem_busy           (mem_busy),
    .ex_branch_valid    (ex_branch_valid),
    .ex_branch_taken    (ex_branch_taken),
    .ex_predicted_taken (ex_predicted_taken),
    .ex_pc              (ex_pc),
    .ex_target          (ex_target),
    .stall              (stall),
    .flush              (flush),
    .nop                (nop),
    .branch_address     (branch_address),
    .mispredict_count   (mispredict_count),
    .stall_count        (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle at the falling edge, check, then advance the model
  task automatic step(input logic r, input logic l, input logic b, input logic v,
                      input logic tk, input logic pr,
                      input logic [15:0] pc, input logic [15:0] tg);
    logic in_win;
    logic e_stall;
    @(negedge clk);
    reset = r; load_use_hazard = l; mem_busy = b; ex_branch_valid = v;
    ex_branch_taken = tk; ex_predicted_taken = pr; ex_pc = pc; ex_target = tg;
    #1;
    in_win  = (cyc >= acc + 1) && (cyc <= acc + FC);
    e_stall = r && (b || (l && !in_win));
    chk("stall", 16'(stall), 16'(e_stall));
    chk("flush", 16'(flush), 16'(cyc == acc + 1));
    chk("nop", 16'(nop), 16'(in_win));
    chk("branch_address", branch_address, m_ba);
    chk("mispredict_count", mispredict_count, PERF ? 16'(m_mis) : 16'd0);
    chk("stall_count", stall_count, PERF ? 16'(m_stall) : 16'd0);
    if (!r) begin
      acc = -1000; m_ba = 16'h0000; m_mis = 0; m_stall = 0;
    end else begin
      if (!in_win && v && !b && (tk != pr)) begin
        acc  = cyc;
        m_ba = tk ? tg : 16'(pc + 16'd2);
        if (m_mis < 65535) m_mis++;
      end
      if (e_stall && (m_stall < 65535)) m_stall++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    reset = 1'b0; load_use_hazard = 1'b0; mem_busy = 1'b0; ex_branch_valid = 1'b0;
    ex_branch_taken = 1'b0; ex_predicted_taken = 1'b0; ex_pc = 16'h0; ex_target = 16'h0;
    @(posedge clk);
    cyc = 0; acc = -1000; m_ba = 16'h0000; m_mis = 0; m_stall = 0;

    // Reset held with toggling inputs
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'(i), 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0100);
    chk("reset_flush", 16'(flush), 16'h0);
    chk("reset_nop", 16'(nop), 16'h0);

    // Correct not-taken prediction: no activity
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0100);
    idle(2);
    chk("correct_pred_nop", 16'(nop), 16'h0);

    // Predicted not-taken, taken to 0x0100
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0100);
    idle(1);
    chk("taken_flush", 16'(flush), 16'h1);
    chk("taken_target", branch_address, 16'h0100);
    idle(3);

    // Predicted taken, not taken at 0xFFFE: fall-through wraps to 0
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE, 16'h1234);
    // Wrong-path mispredict and load-use during the nop window
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0300);
    chk("wrap_address", branch_address, 16'h0000);
    chk("window_stall", 16'(stall), 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0300);
    chk("window_stall2", 16'(stall), 16'h0);
    idle(3);

    // Mispredict held in execute behind mem_busy
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0500, 16'h0A00);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0500, 16'h0A00);
    idle(1);
    chk("busy_release_flush", 16'(flush), 16'h1);
    chk("busy_release_target", branch_address, 16'h0A00);
    idle(3);

    // Reset on the flush cycle abandons the sequence
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0600, 16'h0700);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
    chk("abandon_flush", 16'(flush), 16'h0);
    chk("abandon_nop", 16'(nop), 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0C00);
    idle(4);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom));
    idle(4);

    // Long load-use run saturates the stall counter
    for (int i = 0; i < 70000; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
    chk("stall_saturate", stall_count, PERF ? 16'hFFFF : 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central stall/flush sequencer for the five-stage core, driving the `stall`, `flush`, `nop` and `branch_address` inputs of the program counter and the IF/ID pipeline registers. It merges decode load-use hazards and data-memory back-pressure into one stall. It detects branch mispredictions resolved in execute and runs a fixed-length flush sequence that redirects fetch and squashes wrong-path instructions.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: instruction address width; matches the core `ADDR_WIDTH`.
- `FLUSH_CYCLES`, 2: number of cycles `nop` stays asserted per flush; legal range 1..7.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge of `clk`.
- `load_use_hazard`  in  1: decode requests a one-cycle IF/ID freeze.
- `mem_busy`  in  1: data memory not ready; the whole pipeline freezes.
- `ex_branch_valid`  in  1: a conditional branch sits in execute this cycle.
- `ex_branch_taken`  in  1: resolved outcome of that branch.
- `ex_predicted_taken`  in  1: prediction carried down from fetch (`branch_taken` of the PC).
- `ex_pc`  in  ADDR_WIDTH: address of the branch in execute.
- `ex_target`  in  ADDR_WIDTH: resolved taken target.
- `stall`  out  1: freeze PC and IF/ID; combinational.
- `flush`  out  1: PC loads `branch_address`; registered.
- `nop`  out  1: IF/ID and ID/EX inject bubbles; registered.
- `branch_address`  out  ADDR_WIDTH: corrected fetch address; registered.
- `mispredict_count`  out  16: mispredictions seen since reset (see Configuration).
- `stall_count`  out  16: cycles with `stall`=1 since reset (see Configuration).

## Operation
- States:
  - RUN: normal operation.
  - FLUSH: squash sequence. A 3-bit down-counter `nop_cnt` tracks the remaining squash cycles.
- Acceptance:
  - A resolution is accepted when state=RUN, `ex_branch_valid`=1 and `mem_busy`=0.
  - While `mem_busy`=1 the branch stays in execute, so it is evaluated once, on the cycle `mem_busy` is low.
- Mispredict: an accepted resolution with `ex_branch_taken` != `ex_predicted_taken`.
- RUN -> FLUSH on a mispredict. On that edge:
  - `flush` <= 1.
  - `nop` <= 1.
  - `nop_cnt` <= FLUSH_CYCLES-1.
  - `branch_address` <= `ex_branch_taken` ? `ex_target` : `ex_pc`+2. Modulo 2^ADDR_WIDTH; `ex_pc`=all-ones-minus-1 wraps to 0.
- FLUSH:
  - `flush` returns to 0 after exactly one cycle.
  - `nop` stays 1 while `nop_cnt`!=0; `nop_cnt` decrements each cycle.
  - When `nop_cnt`=0, the next edge returns to RUN with `nop` <= 0.
  - With FLUSH_CYCLES=1 the sequence is one cycle: `flush` and `nop` both high, then back to RUN.
- Wrong-path suppression: while state=FLUSH, `ex_branch_valid` and `load_use_hazard` are ignored.
- `stall` = `mem_busy` | (`load_use_hazard` & state==RUN).
  - `mem_busy` stalls in every state.
  - The FLUSH sequence advances even during `mem_busy`. The PC gives `flush` priority over `stall`, so the redirect is never lost.
- Correct predictions produce no output activity.
- Reset (`reset`=0 at an edge):
  - state=RUN, `nop_cnt`=0.
  - `flush`=0, `nop`=0, `branch_address`=0, both counters=0.
  - Reset overrides all inputs; a reset mid-FLUSH abandons the sequence.
  - `stall` is also forced to 0 while `reset`=0.

## Timing
- Mispredict accepted in cycle t:
  - `flush`=1 and `branch_address` valid in cycle t+1.
  - The PC holds the corrected address from cycle t+2.
- `nop` is high for cycles t+1 .. t+FLUSH_CYCLES.
- A new mispredict can be accepted no earlier than cycle t+FLUSH_CYCLES+1.
- `stall` has zero latency: it is combinational from inputs and state.
- `mispredict_count` and `stall_count` are registered, one cycle behind the event.

## Configuration
- Macro `PIPELINE_CONTROL_PERF_EN`.
- Defined:
  - `mispredict_count` increments on each accepted mispredict.
  - `stall_count` increments on each cycle with `stall`=1.
  - Both saturate at 16'hFFFF.
- Undefined:
  - Both ports remain present and are tied to 0.
  - No counter flops are synthesized.
  - Control behaviour is identical.

## Test plan
- Reset held low 3 cycles with all inputs toggling -> every output 0. Release; predicted-not-taken branch actually not taken, `ex_pc`=16'h0040 -> no `flush`, no `nop`.
- RUN, `ex_pc`=16'h0040, predicted not-taken, actually taken, `ex_target`=16'h0100 (FLUSH_CYCLES=2) -> next cycle `flush`=1, `branch_address`=16'h0100. `nop`=1 for exactly 2 cycles. `mispredict_count`=1 with PERF_EN.
- Predicted taken, actually not taken, `ex_pc`=16'hFFFE -> `branch_address`=16'h0000 (wrap). A second mispredict and a `load_use_hazard` presented during the `nop` window -> both ignored; `stall`=0.
- `mem_busy`=1 for 4 cycles with a mispredicting branch held in execute -> `stall`=1 for 4 cycles, no `flush`. On the first `mem_busy`=0 cycle the mispredict is accepted; exactly one `flush` follows.
- Mispredict accepted, then `reset`=0 on the cycle `flush`=1 -> next cycle `flush`=0, `nop`=0, state RUN. The next mispredict produces a normal full sequence.
- PERF_EN build: `load_use_hazard`=1 for 70000 cycles -> `stall_count` saturates at 16'hFFFF. Non-PERF build: same stimulus -> counters read 0.
